bin2bcd_arbiter: RTL

- Shares one bin2bcd16 converter (en/bin in; bcd0..bcd4, busy, fin out) between NREQ requesters.
- Arbitrates round-robin and launches one conversion at a time.
- Waits for fin, returns the 5-digit result to the winner with a one-cycle ack, then waits for the converter to go idle before the next grant.
- Sits between display/formatting clients and the converter instance.

---
 rtl/bin2bcd_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/bin2bcd_arbiter.sv
// bin2bcd_arbiter
// Shares a single bin2bcd16 converter between NREQ requesters using a
// round-robin arbiter. One conversion is in flight at a time. The result is
// returned to the winner with a one-cycle ack. The next grant is issued only
// after the converter has gone idle again.
//
// Parameters
//   NREQ            number of requesters (2..8)
//   TIMEOUT_CYCLES  WAIT cycles allowed before a conversion is abandoned
//                   (only used when BIN2BCD_ARB_TIMEOUT_EN is defined)
//
// Ports
//   CLK            clock, rising edge
//   RST            asynchronous active-low reset
//   req            per-requester request level
//   bin_in         packed operands, requester k at [16k+15:16k]
//   ack            one-hot, one-cycle result strobe
//   bcd_out        {d4,d3,d2,d1,d0}, held until the next ack
//   grant_id       current/last granted requester
//   arb_busy       high whenever the FSM is not in IDLE
//   conv_en        converter start pulse
//   conv_bin       converter operand
//   conv_bcd0..4   converter result digits
//   conv_busy      converter busy
//   conv_fin       converter done pulse
//   timeout_err    sticky timeout flag (BIN2BCD_ARB_TIMEOUT_EN only)
//
// Optional feature macro: BIN2BCD_ARB_TIMEOUT_EN
//
// state  | meaning
// IDLE   | wait for a request while the converter is idle
// LAUNCH | conv_en high for this single cycle
// WAIT   | wait for conv_fin (or the timeout)
// DONE   | ack pulse to the granted requester
// DRAIN  | wait for conv_busy to fall before the next grant
module bin2bcd_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req,
  input  logic [16*NREQ-1:0] bin_in,
  output logic [NREQ-1:0]    ack,
  output logic [19:0]        bcd_out,
  output logic [2:0]         grant_id,
  output logic               arb_busy,
  output logic               conv_en,
  output logic [15:0]        conv_bin,
  input  logic [3:0]         conv_bcd0,
  input  logic [3:0]         conv_bcd1,
  input  logic [3:0]         conv_bcd2,
  input  logic [3:0]         conv_bcd3,
  input  logic [3:0]         conv_bcd4,
  input  logic               conv_busy,
  input  logic               conv_fin
`ifdef BIN2BCD_ARB_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE, S_DRAIN} state_t;

  state_t     state;
  logic [2:0] last;
  logic [2:0] winner;

  assign grant_id = last;

  // Round-robin pick: smallest distance from last+1 (mod NREQ) among the
  // active requests. Only used when |req is true.
  always_comb begin
    int best_d;
    int d;
    winner = last;
    best_d = NREQ;
    for (int j = 0; j < NREQ; j++) begin
      d = (j + 2 * NREQ - int'(last) - 1) % NREQ;
      if (req[j] && (d < best_d)) begin
        best_d = d;
        winner = 3'(j);
      end
    end
  end

`ifdef BIN2BCD_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  // Down-counter: loaded on entry to WAIT, terminal count means the
  // TIMEOUT_CYCLES-th WAIT cycle has elapsed without conv_fin.
  logic [TW-1:0] tcnt;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      last     <= 3'(NREQ - 1);
      ack      <= '0;
      bcd_out  <= '0;
      arb_busy <= 1'b0;
      conv_en  <= 1'b0;
      conv_bin <= '0;
`ifdef BIN2BCD_ARB_TIMEOUT_EN
      tcnt        <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      conv_en <= 1'b0;
      ack     <= '0;
      case (state)
        S_IDLE: begin
          if ((|req) && !conv_busy) begin
            state    <= S_LAUNCH;
            last     <= winner;
            conv_bin <= bin_in[16*int'(winner) +: 16];
            conv_en  <= 1'b1;
            arb_busy <= 1'b1;
          end
        end
        S_LAUNCH: begin
          state <= S_WAIT;
`ifdef BIN2BCD_ARB_TIMEOUT_EN
          tcnt  <= TW'(TIMEOUT_CYCLES - 1);
`endif
        end
        S_WAIT: begin
          if (conv_fin) begin
            bcd_out <= {conv_bcd4, conv_bcd3, conv_bcd2, conv_bcd1, conv_bcd0};
            ack     <= NREQ'(1) << last;
            state   <= S_DONE;
          end
`ifdef BIN2BCD_ARB_TIMEOUT_EN
          else if (tcnt == '0) begin
            bcd_out     <= 20'hFFFFF;
            ack         <= NREQ'(1) << last;
            timeout_err <= 1'b1;
            state       <= S_DONE;
          end else begin
            tcnt <= tcnt - 1'b1;
          end
`endif
        end
        S_DONE: begin
          state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!conv_busy) begin
            state    <= S_IDLE;
            arb_busy <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          arb_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
